// File: rtl/wide_add_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the word-serial wide adder.
//   WORD_W       : width of one datapath word (the shared 16-bit adder)
//   state_t      : controller state encoding (IDLE, ADD, DONE)
//   idx_width()  : width of a word index counter for a given word count
// -----------------------------------------------------------------------------
package wide_add_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-word operand would still need a one-bit counter to keep the
    // index vector non-empty, so the width never drops below 1.
    function automatic int idx_width(input int num_words);
        int w;
        w = $clog2(num_words);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : wide_add_pkg

// File: rtl/wide_add_seq_if.sv
// -----------------------------------------------------------------------------
// wide_add_seq_if
// Request/response bundle between a requesting FSM (master) and the
// word-serial wide adder (slave).
//   start     : master -> slave, request; only honoured while the adder is idle
//   a_in      : master -> slave, operand A (W bits)
//   b_in      : master -> slave, operand B (W bits)
//   carry_in  : master -> slave, carry into word 0
//   busy      : slave -> master, operation in progress (ADD or DONE)
//   done      : slave -> master, one-cycle pulse, sum_out/overflow valid
//   sum_out   : slave -> master, result register (W bits)
//   overflow  : slave -> master, carry out of the most-significant word
// -----------------------------------------------------------------------------
interface wide_add_seq_if
    import wide_add_pkg::*;
#(
    parameter int NUM_WORDS = 4
) ();

    localparam int W = WORD_W * NUM_WORDS;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         overflow;

    modport master (
        output start,
        output a_in,
        output b_in,
        output carry_in,
        input  busy,
        input  done,
        input  sum_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  a_in,
        input  b_in,
        input  carry_in,
        output busy,
        output done,
        output sum_out,
        output overflow
    );

endinterface : wide_add_seq_if

// File: rtl/adder_16bit.sv
// -----------------------------------------------------------------------------
// adder_16bit
// Plain 16-bit unsigned ripple adder with carry in and carry out.
//   a, b      : 16-bit addends
//   carry_in  : carry into bit 0
//   sum       : low 16 bits of a + b + carry_in
//   overflow  : bit 16 of a + b + carry_in
// -----------------------------------------------------------------------------
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);

    // Widen every term to 17 bits so the carry out lands in the top bit.
    logic [16:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
    assign sum      = full_sum[15:0];
    assign overflow = full_sum[16];

endmodule : adder_16bit

// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
// Word-serial unsigned adder for NUM_WORDS*16-bit operands built around one
// shared adder_16bit. One word is added per clock, least-significant word
// first, with the inter-word carry held in a register.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, wins over everything else
//   bus   : wide_add_seq_if slave port (start/a_in/b_in/carry_in in,
//           busy/done/sum_out/overflow out)
// Timing: start sampled in IDLE at E0, words computed at E1..EN, done high
// for the cycle between EN and EN+1, back in IDLE after EN+1.
// -----------------------------------------------------------------------------
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);

    localparam int W     = WORD_W * NUM_WORDS;
    localparam int IDX_W = idx_width(NUM_WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // State register is kept as a plain vector; the constants take their
    // values from the shared enum so the encoding lives in one place.
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_ADD  = ADD;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry_reg;
    logic [W-1:0]     sum_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WORD_W-1:0] word_a;
    logic [WORD_W-1:0] word_b;
    logic [WORD_W-1:0] word_sum;
    logic              word_carry;

    // Word selection for the shared adder: the current index picks one slice
    // of each latched operand.
    always_comb begin
        word_a = a_reg[idx*WORD_W +: WORD_W];
        word_b = b_reg[idx*WORD_W +: WORD_W];
    end

    adder_16bit u_adder (
        .a        (word_a),
        .b        (word_b),
        .carry_in (carry_reg),
        .sum      (word_sum),
        .overflow (word_carry)
    );

    // Controller: operand capture, per-word accumulation and the
    // registered busy/done outputs. busy and done are assigned alongside each
    // state transition so they always reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            sum_reg      <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a_in;
                        b_reg     <= bus.b_in;
                        carry_reg <= bus.carry_in;
                        idx       <= '0;
                        state     <= S_ADD;
                        busy_reg  <= 1'b1;
                    end
                end
                S_ADD: begin
                    sum_reg[idx*WORD_W +: WORD_W] <= word_sum;
                    carry_reg <= word_carry;
                    // After the last word idx may wrap or step past the
                    // final word, but it is unused until the next capture
                    // reloads it.
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        overflow_reg <= word_carry;
                        state        <= S_DONE;
                        done_reg     <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy_reg <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.sum_out  = sum_reg;
    assign bus.overflow = overflow_reg;

endmodule : wide_add_seq

// File: tb/tb_wide_add_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_add_seq
// Self-checking bench for wide_add_seq with NUM_WORDS = 4 (64-bit operands).
// Expected results are queued when a request is accepted and compared when
// the DUT raises done.
// -----------------------------------------------------------------------------
module tb_wide_add_seq;

    localparam int NW = 4;
    localparam int W  = 16 * NW;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;

    int nChecks   = 0;
    int nFails    = 0;
    int doneCount = 0;
    int opsIssued = 0;

    exp_t expQ[$];
    vec_t vecs[8];

    wide_add_seq_if #(.NUM_WORDS(NW)) bus ();

    wide_add_seq #(.NUM_WORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard side: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            doneCount++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pulse (sum_out=%h)",
                         bus.sum_out);
            end else begin
                e = expQ.pop_front();
                checkOutput("sum_out", bus.sum_out, e.sum);
                checkOutput("overflow", W'(bus.overflow), W'(e.ovf));
            end
        end
    end

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One full operation: request at E0, done expected after E4 for one
    // cycle, idle again after E5 with the result still held.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [W-1:0] es,
                                 input logic eo);
        int cycles;
        @(negedge clk);
        bus.a_in     = a;
        bus.b_in     = b;
        bus.carry_in = cin;
        bus.start    = 1'b1;
        @(posedge clk);
        expQ.push_back('{sum: es, ovf: eo});
        opsIssued++;
        #1;
        bus.start    = 1'b0;
        bus.a_in     = rand64();
        bus.b_in     = rand64();
        bus.carry_in = ~cin;
        checkOutput("busy_after_start", W'(bus.busy), W'(1'b1));
        checkOutput("done_low_after_start", W'(bus.done), W'(1'b0));
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("done_latency", W'(cycles), W'(NW));
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", W'(bus.done), W'(1'b0));
        checkOutput("busy_after_done", W'(bus.busy), W'(1'b0));
        checkOutput("sum_held_idle", bus.sum_out, es);
    endtask

    initial begin
        int doneBefore;
        logic [W:0] model;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        vecs[0] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0};
        vecs[1] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4] = '{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0,
                    64'h0011_0022_0033_0044, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        vecs[6] = '{64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0001_0000_0000_0000, 1'b0};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0};

        // Reset held for two edges with start asserted.
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.a_in     = 64'h1111_2222_3333_4444;
        bus.b_in     = 64'h5555_6666_7777_8888;
        bus.carry_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", W'(bus.busy), W'(1'b0));
        checkOutput("reset_done", W'(bus.done), W'(1'b0));
        checkOutput("reset_sum", bus.sum_out, 64'h0);
        checkOutput("reset_overflow", W'(bus.overflow), W'(1'b0));
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("no_op_after_reset", W'(bus.busy), W'(1'b0));

        $display("[TB] table-driven vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].ovf);
        end

        $display("[TB] random vectors");
        for (int i = 0; i < 4; i++) begin
            ra    = rand64();
            rb    = rand64();
            rc    = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            applyStimulus(ra, rb, rc, model[W-1:0], model[W]);
        end

        // Start requests while busy, including during DONE, are ignored.
        $display("[TB] start while busy");
        @(negedge clk);
        bus.a_in     = 64'd10;
        bus.b_in     = 64'd10;
        bus.carry_in = 1'b1;
        bus.start    = 1'b1;
        @(posedge clk);
        expQ.push_back('{sum: 64'd21, ovf: 1'b0});
        opsIssued++;
        #1;
        bus.start    = 1'b0;
        bus.a_in     = 64'd5;
        bus.b_in     = 64'd5;
        bus.carry_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy_mid_op", W'(bus.busy), W'(1'b1));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("done_at_E4", W'(bus.done), W'(1'b1));
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("idle_after_E5", W'(bus.busy), W'(1'b0));
        repeat (6) @(posedge clk);
        #1;
        checkOutput("ignored_start_no_op", W'(bus.busy), W'(1'b0));
        checkOutput("ignored_start_sum", bus.sum_out, 64'd21);

        // Reset mid-operation abandons the request without a done pulse.
        $display("[TB] reset mid-operation");
        @(negedge clk);
        bus.a_in     = 64'd12000;
        bus.b_in     = 64'd1;
        bus.carry_in = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        doneBefore = doneCount;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_busy", W'(bus.busy), W'(1'b0));
        checkOutput("abort_done", W'(bus.done), W'(1'b0));
        checkOutput("abort_sum", bus.sum_out, 64'h0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("abort_no_done", W'(doneCount), W'(doneBefore));
        checkOutput("abort_still_idle", W'(bus.busy), W'(1'b0));
        applyStimulus(64'd1, 64'd13456, 1'b0, 64'd13457, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", W'(expQ.size()), W'(0));
        checkOutput("done_pulse_count", W'(doneCount), W'(opsIssued));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_wide_add_seq
